// File: rtl/rx_iq_rate_ctrl.sv
// RX I/Q FIFO read-rate controller.
// Schedules FIFO reads at a nominal sample rate, nudges the sample period
// according to FIFO fill level, and keeps saturating underflow/overflow stats.
module rx_iq_rate_ctrl #(
    parameter int unsigned COUNT_TOP = 4,
    parameter int unsigned FRAC_EN   = 0,
    parameter int unsigned LOW_TH    = 11,
    parameter int unsigned HIGH_TH   = 22
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        bypass_en,
    input  logic [5:0]  fifo_data_count,
    input  logic        fifo_empty,
    input  logic        fifo_full,
    input  logic        clr_stats,
    output logic        rd_en,
    output logic        sample_tick,
    output logic [4:0]  counter_top_cur,
    output logic [1:0]  state,
    output logic [15:0] underflow_cnt,
    output logic [15:0] overflow_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam logic [5:0] LP_LOW    = 6'(LOW_TH);
    localparam logic [5:0] LP_HIGH   = 6'(HIGH_TH);
    localparam logic [4:0] LP_TOP    = 5'(COUNT_TOP);
    localparam logic [4:0] LP_TOP_P1 = 5'(COUNT_TOP + 1);
    localparam logic [4:0] LP_TOP_M1 = 5'(COUNT_TOP - 1);

    state_t      r_state;
    logic [4:0]  r_counter;
    logic [4:0]  r_top;
    logic        r_flag;
    logic        r_full_q;
    logic [15:0] r_underflow_cnt;
    logic [15:0] r_overflow_cnt;

    logic        w_tick;
    logic        w_underflow;
    logic        w_full_rise;
    logic [4:0]  w_top_next;

    assign w_tick      = (r_state == RUN) && (r_counter == '0);
    assign w_underflow = w_tick & fifo_empty & ~bypass_en;
    assign w_full_rise = fifo_full & ~r_full_q;

    // Period selection from fill level; dither mode alternates between two periods mid-band.
    always_comb begin
        w_top_next = LP_TOP;
        if (fifo_data_count < LP_LOW) begin
            w_top_next = LP_TOP_P1;
        end else if (fifo_data_count < LP_HIGH) begin
            if (FRAC_EN != 0) begin
                w_top_next = r_flag ? LP_TOP : LP_TOP_P1;
            end else begin
                w_top_next = LP_TOP;
            end
        end else begin
            w_top_next = (FRAC_EN != 0) ? LP_TOP : LP_TOP_M1;
        end
    end

    // State machine and slot counter; the counter only runs in RUN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_counter <= '0;
        end else if (!en) begin
            r_state   <= IDLE;
            r_counter <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state   <= PREFILL;
                    r_counter <= '0;
                end
                PREFILL: begin
                    if (fifo_data_count >= LP_LOW) begin
                        r_state <= RUN;
                    end
                    r_counter <= '0;
                end
                RUN: begin
                    if (w_underflow) begin
                        r_state   <= PREFILL;
                        r_counter <= '0;
                    end else if (r_counter >= r_top) begin
                        r_counter <= '0;
                    end else begin
                        r_counter <= r_counter + 5'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_counter <= '0;
                end
            endcase
        end
    end

    // Active period and dither flag latch on each tick; the new period governs the slot just started.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_top  <= LP_TOP;
            r_flag <= 1'b0;
        end else if (w_tick) begin
            r_top  <= w_top_next;
            r_flag <= ~r_flag;
        end
    end

    // Saturating statistics; clear wins over a coincident event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_underflow_cnt <= '0;
            r_overflow_cnt  <= '0;
            r_full_q        <= 1'b0;
        end else begin
            r_full_q <= fifo_full;
            if (clr_stats) begin
                r_underflow_cnt <= '0;
                r_overflow_cnt  <= '0;
            end else begin
                if (w_underflow && (r_underflow_cnt != '1)) begin
                    r_underflow_cnt <= r_underflow_cnt + 16'd1;
                end
                if (w_full_rise && (r_overflow_cnt != '1)) begin
                    r_overflow_cnt <= r_overflow_cnt + 16'd1;
                end
            end
        end
    end

    // Read strobe is gated by rstn so it drops immediately in reset, even in bypass.
    assign rd_en = rstn & (bypass_en ? (en & ~fifo_empty) : (w_tick & ~fifo_empty));

    assign sample_tick     = w_tick;
    assign counter_top_cur = r_top;
    assign state           = r_state;
    assign underflow_cnt   = r_underflow_cnt;
    assign overflow_cnt    = r_overflow_cnt;

endmodule

// File: tb/tb_rx_iq_rate_ctrl.sv
// Bench for rx_iq_rate_ctrl: integer and dithered instances driven in parallel.
module tb_rx_iq_rate_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        bypass_en;
    logic [5:0]  fifo_data_count;
    logic        fifo_empty;
    logic        fifo_full;
    logic        clr_stats;

    logic [1:0]  rd;
    logic [1:0]  tick;
    logic [4:0]  top   [2];
    logic [1:0]  st    [2];
    logic [15:0] under [2];
    logic [15:0] over  [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected read cycles per instance
    int q0[$];
    int q1[$];

    // Reference model: sample-slot view (mode, cycle of next tick, current period)
    int m_mode  [2];
    int m_next  [2];
    int m_top   [2];
    bit m_flag  [2];
    bit m_fprev [2];
    int m_under [2];
    int m_over  [2];

    always #5 clk = ~clk;

    rx_iq_rate_ctrl #(.COUNT_TOP(4), .FRAC_EN(0), .LOW_TH(11), .HIGH_TH(22)) dut0 (
        .clk(clk), .rstn(rstn), .en(en), .bypass_en(bypass_en),
        .fifo_data_count(fifo_data_count), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .clr_stats(clr_stats),
        .rd_en(rd[0]), .sample_tick(tick[0]), .counter_top_cur(top[0]),
        .state(st[0]), .underflow_cnt(under[0]), .overflow_cnt(over[0])
    );

    rx_iq_rate_ctrl #(.COUNT_TOP(4), .FRAC_EN(1), .LOW_TH(11), .HIGH_TH(22)) dut1 (
        .clk(clk), .rstn(rstn), .en(en), .bypass_en(bypass_en),
        .fifo_data_count(fifo_data_count), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .clr_stats(clr_stats),
        .rd_en(rd[1]), .sample_tick(tick[1]), .counter_top_cur(top[1]),
        .state(st[1]), .underflow_cnt(under[1]), .overflow_cnt(over[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qfront(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpop(input int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_next[k] = 0; m_top[k] = 4; m_flag[k] = 1'b0;
            m_fprev[k] = 1'b0; m_under[k] = 0; m_over[k] = 0;
        end
    endfunction

    // Predict this cycle's read and advance the model to the next cycle
    function automatic void model_eval();
        for (int k = 0; k < 2; k++) begin
            bit t;
            bit r;
            int p;
            t = (m_mode[k] == 2) && (cyc == m_next[k]);
            r = bypass_en ? (en && !fifo_empty) : (t && !fifo_empty);
            if (r) begin
                if (k == 0) q0.push_back(cyc);
                else        q1.push_back(cyc);
            end
            if (t) begin
                if (fifo_data_count < 11)      p = 6;
                else if (fifo_data_count < 22) p = (k == 1 && !m_flag[k]) ? 6 : 5;
                else                           p = (k == 1) ? 5 : 4;
                m_top[k]  = p - 1;
                m_flag[k] = !m_flag[k];
                m_next[k] = cyc + p;
            end
            if (clr_stats) begin
                m_under[k] = 0;
                m_over[k]  = 0;
            end else begin
                if (t && fifo_empty && !bypass_en && m_under[k] < 65535) m_under[k]++;
                if (fifo_full && !m_fprev[k] && m_over[k] < 65535) m_over[k]++;
            end
            m_fprev[k] = fifo_full;
            if (!en) m_mode[k] = 0;
            else if (m_mode[k] == 0) m_mode[k] = 1;
            else if (m_mode[k] == 1) begin
                if (fifo_data_count >= 11) begin
                    m_mode[k] = 2;
                    m_next[k] = cyc + 1;
                end
            end else if (t && fifo_empty && !bypass_en) m_mode[k] = 1;
        end
    endfunction

    task automatic status_chk();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("state[%0d]", k), int'(st[k]), m_mode[k]);
            chk($sformatf("counter_top_cur[%0d]", k), int'(top[k]), m_top[k]);
            chk($sformatf("underflow_cnt[%0d]", k), int'(under[k]), m_under[k]);
            chk($sformatf("overflow_cnt[%0d]", k), int'(over[k]), m_over[k]);
        end
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        status_chk();
    endtask

    task automatic run(input int n, input int cnt, input bit emp);
        fifo_data_count = 6'(cnt);
        fifo_empty      = emp;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset: outputs checked with no clock edge in between
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_state[%0d]", k), int'(st[k]), 0);
            chk($sformatf("rst_rd_en[%0d]", k), int'(rd[k]), 0);
            chk($sformatf("rst_tick[%0d]", k), int'(tick[k]), 0);
            chk($sformatf("rst_top[%0d]", k), int'(top[k]), 4);
            chk($sformatf("rst_under[%0d]", k), int'(under[k]), 0);
            chk($sformatf("rst_over[%0d]", k), int'(over[k]), 0);
        end
        q0.delete();
        q1.delete();
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Monitor: every read strobe must match the head of the expected-read queue
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (qsize(k) > 0 && qfront(k) == cyc) begin
                checks++;
                if (!rd[k]) begin
                    errors++;
                    $display("FAIL rd_en[%0d] missing: got 0 expected 1 (cycle %0d)", k, cyc);
                end
                qpop(k);
            end else if (rd[k]) begin
                checks++;
                errors++;
                $display("FAIL rd_en[%0d] unexpected: got 1 expected 0 (cycle %0d)", k, cyc);
            end
        end
    end

    initial begin
        rstn = 1'b0; en = 1'b0; bypass_en = 1'b0; fifo_data_count = '0;
        fifo_empty = 1'b1; fifo_full = 1'b0; clr_stats = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Prefill below threshold, then run at nominal rate
        en = 1'b1;
        run(6, 5, 1'b0);
        run(22, 15, 1'b0);
        // Fast and slow adaptation
        run(22, 25, 1'b0);
        run(26, 3, 1'b0);
        // Underflow, then underflow with simultaneous clear
        run(10, 15, 1'b1);
        clr_stats = 1'b1;
        run(8, 15, 1'b1);
        clr_stats = 1'b0;
        run(10, 15, 1'b0);

        // Reset in the middle of RUN, with bypass armed so an ungated strobe would show
        bypass_en = 1'b1;
        do_reset();
        bypass_en = 1'b0;

        // Bypass: eight consecutive reads
        bypass_en = 1'b1;
        run(8, 15, 1'b0);
        bypass_en = 1'b0;

        // Three fifo_full pulses
        for (int i = 0; i < 3; i++) begin
            fifo_full = 1'b1; cycle();
            fifo_full = 1'b0; cycle();
        end

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            en              = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 19) == 0) bypass_en = ~bypass_en;
            fifo_data_count = 6'($urandom_range(0, 40));
            fifo_empty      = ($urandom_range(0, 9) == 0);
            fifo_full       = ($urandom_range(0, 3) == 0);
            clr_stats       = ($urandom_range(0, 39) == 0);
            cycle();
        end
        en = 1'b0; bypass_en = 1'b0; fifo_full = 1'b0; clr_stats = 1'b0;
        cycle();

        // Overflow saturation: preload one below the ceiling, then pulse twice
        force dut0.r_overflow_cnt = 16'hFFFE;
        force dut1.r_overflow_cnt = 16'hFFFE;
        m_over[0] = 65534;
        m_over[1] = 65534;
        cycle();
        release dut0.r_overflow_cnt;
        release dut1.r_overflow_cnt;
        for (int i = 0; i < 2; i++) begin
            fifo_full = 1'b1; cycle();
            fifo_full = 1'b0; cycle();
        end
        chk("overflow_sat[0]", int'(over[0]), 65535);
        chk("overflow_sat[1]", int'(over[1]), 65535);

        @(negedge clk);
        chk("pending_reads[0]", q0.size(), 0);
        chk("pending_reads[1]", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
